sobel_frame_ctrl: RTL and testbench
===================================

// Module: sobel_frame_ctrl
// PURPOSE
//  Sequencer for the 8x8 Sobel frame engine. Runs one frame at a time:
//  load 64 pixels, sweep one shared clocked sobel core over the 36 interior
//  windows, then unload the 64 results. Valid/ready on both sides. Drives
//  addresses and enables only; pixel and result storage live in the datapath.
// PARAMETERS
//  SIDE      8  image side in pixels; frame = SIDE*SIDE (64)
//  ADDR_W    6  address width, log2(SIDE*SIDE)
//  SOBEL_LAT 1  sobel core latency in clocks, legal 1..4
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  start       in   1       begin frame; sampled only in IDLE
//  in_valid    in   1       upstream pixel valid
//  in_ready    out  1       ready for pixel (high only in LOAD)
//  wr_en       out  1       pixel write strobe = in_valid & in_ready
//  wr_addr     out  ADDR_W  pixel write address
//  win_valid   out  1       window present to sobel core this cycle
//  win_base    out  ADDR_W  window top-left address (p0); p4 = base+SIDE+1
//  res_wr_en   out  1       write sobel output into result store
//  res_addr    out  ADDR_W  result address = delayed win_base + SIDE + 1
//  out_valid   out  1       result beat valid (high only in UNLOAD)
//  out_ready   in   1       downstream accepts beat
//  rd_addr     out  ADDR_W  result read address
//  border_zero out  1       rd_addr is a border pixel; datapath outputs 0
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle pulse after the last result beat
// BEHAVIOUR
//  Reset: state IDLE. All counters 0. All outputs 0. Latency pipe cleared.
//  States and transitions (registered):
//  - IDLE: start=1 -> LOAD.
//  - LOAD: in_ready=1. Each in_valid beat writes wr_addr, then wr_addr++.
//    The beat at addr SIDE*SIDE-1 -> COMPUTE; wr_addr wraps to 0.
//  - COMPUTE: win_valid=1 for (SIDE-2)^2 = 36 cycles, no stalls.
//    win_base = SIDE*r + c, with c fastest, r,c in 0..SIDE-3
//    (0,1..5,8..13,...,45). After the last window -> DRAIN.
//  - DRAIN: SOBEL_LAT cycles, then UNLOAD.
//  - UNLOAD: out_valid=1. rd_addr advances only on out_valid & out_ready.
//    The beat at addr 63 -> IDLE, done=1 for that first IDLE cycle.
//  Sobel timing: res_wr_en and res_addr are win_valid and win_base+SIDE+1
//  delayed SOBEL_LAT cycles through a shift pipe. Writes span 9..54.
//  border_zero = out_valid & (row==0 | row==SIDE-1 | col==0 | col==SIDE-1)
//  of rd_addr. That is 28 positions; result store is not cleared.
//  Ignored inputs:
//  - start outside IDLE: ignored; no queuing.
//  - in_valid outside LOAD: no write, in_ready=0.
//  - out_ready outside UNLOAD: ignored.
//  Back-pressure: stalled in_valid or out_ready holds wr_addr / rd_addr stable.
//  Address arithmetic: unsigned, ADDR_W bits, no overflow inside a frame.
//  start in the cycle done pulses is accepted (state is IDLE).
//  reset mid-operation: returns to IDLE next edge. No res_wr_en or done
//  fires afterwards, including pending latency-pipe entries.
//  Cycle budget, no stalls, LAT=1, start sampled at edge 0:
//  LOAD 1..64, COMPUTE 65..100, DRAIN 101, UNLOAD 102..165, done at 166.
// TESTING
//  1 Streaming frame, in_valid=out_ready=1, SOBEL_LAT=1, pixels=addr ->
//    cycle counts above; 36 res_wr_en at 66..101, res_addr 9..54 interior
//    only; 64 out beats, rd_addr 0..63.
//  2 LOAD back-pressure: in_valid toggled 1,0 ->
//    exactly 64 wr_en, wr_addr held while in_valid=0, COMPUTE after beat 64.
//  3 UNLOAD back-pressure: out_ready low 5 cycles at rd_addr=20 ->
//    rd_addr stays 20, out_valid stays 1, done still after addr 63 accepted.
//  4 SOBEL_LAT=3 -> DRAIN 3 cycles. First res_wr_en 3 cycles after first
//    win_valid. border_zero=1 on rd_addr 0..8,15,16,... (28 beats), 0 on 9.
//  5 start pulsed during COMPUTE, and in_valid held high during UNLOAD ->
//    no state change, no wr_en; single frame completes normally.
//  6 reset asserted at COMPUTE cycle 10 -> IDLE next edge, busy=0,
//    no further res_wr_en or done; a new start runs a clean frame.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame sequencer for the 8x8 Sobel engine. One frame at a time it loads
// SIDE*SIDE pixels, sweeps a single shared sobel core across the (SIDE-2)^2
// interior 3x3 windows, waits for the core latency to drain, then streams
// the SIDE*SIDE results out. Only addresses and strobes are produced here;
// pixel and result storage live in the datapath.
//
// Ports
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         begin a frame (looked at only while idle)
//   in_valid      upstream pixel valid        in_ready  high only in LOAD
//   wr_en         pixel write strobe          wr_addr   pixel write address
//   win_valid     window presented to core    win_base  window top-left address
//   res_wr_en     core output write strobe    res_addr  window centre address
//   out_valid     result beat valid           out_ready downstream accepts beat
//   rd_addr       result read address         border_zero rd_addr is a border pixel
//   busy          not idle                    done      one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module sobel_frame_ctrl #(
    parameter int SIDE      = 8,
    parameter int ADDR_W    = 6,
    parameter int SOBEL_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_base,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              border_zero,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_UNLOAD  = 3'd4
    } state_e;

    localparam int COL_W = $clog2(SIDE);

    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(SIDE * SIDE - 1);
    // Top-left corner of the bottom-right interior window.
    localparam logic [ADDR_W-1:0] LAST_WIN   = ADDR_W'(SIDE * (SIDE - 3) + SIDE - 3);
    // Offset from window top-left (p0) to its centre pixel (p4).
    localparam logic [ADDR_W-1:0] CENTER_OFS = ADDR_W'(SIDE + 1);
    // From the last window of a row (col SIDE-3) to col 0 of the next row.
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ONE_ADDR   = ADDR_W'(1);
    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(SIDE - 3);
    localparam logic [COL_W-1:0]  ONE_COL    = COL_W'(1);
    localparam logic [1:0]        LAST_DRAIN = 2'(SOBEL_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [COL_W-1:0]  win_col_q, win_col_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              win_valid_q, win_valid_d;
    logic              out_valid_q, out_valid_d;
    logic              border_zero_q, border_zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SOBEL_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [ADDR_W-1:0]    pipe_a_q [SOBEL_LAT];
    logic [ADDR_W-1:0]    pipe_a_d [SOBEL_LAT];

    // True when the address lies on the outer ring of the frame.
    function automatic logic is_border(input logic [ADDR_W-1:0] a);
        int row;
        int col;
        row = int'(a) / SIDE;
        col = int'(a) % SIDE;
        return (row == 0) || (row == SIDE - 1) || (col == 0) || (col == SIDE - 1);
    endfunction

    // Pixel write strobe is a pure handshake so upstream sees no extra latency.
    assign wr_en = in_valid & in_ready_q;

    // Next-state, address counters and the registered output flags.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        win_base_d  = win_base_q;
        win_col_d   = win_col_q;
        rd_addr_d   = rd_addr_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (wr_en) begin
                    if (wr_addr_q == LAST_PIX) begin
                        state_d   = S_COMPUTE;
                        wr_addr_d = '0;
                    end else begin
                        wr_addr_d = wr_addr_q + ONE_ADDR;
                    end
                end else begin
                    wr_addr_d = wr_addr_q;
                end
            end
            S_COMPUTE: begin
                // Base and column restart at 0 so the next frame begins clean.
                if (win_base_q == LAST_WIN) begin
                    state_d     = S_DRAIN;
                    win_base_d  = '0;
                    win_col_d   = '0;
                    drain_cnt_d = '0;
                end else if (win_col_q == LAST_COL) begin
                    win_col_d  = '0;
                    win_base_d = win_base_q + ROW_STEP;
                end else begin
                    win_col_d  = win_col_q + ONE_COL;
                    win_base_d = win_base_q + ONE_ADDR;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d     = S_UNLOAD;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (rd_addr_q == LAST_PIX) begin
                        state_d   = S_IDLE;
                        rd_addr_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ONE_ADDR;
                    end
                end else begin
                    rd_addr_d = rd_addr_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags are decoded from the next state so they leave the block as flops.
        in_ready_d    = (state_d == S_LOAD);
        win_valid_d   = (state_d == S_COMPUTE);
        out_valid_d   = (state_d == S_UNLOAD);
        busy_d        = (state_d != S_IDLE);
        border_zero_d = out_valid_d & is_border(rd_addr_d);
    end

    // Latency pipe mirroring the sobel core: stage 0 captures this cycle's window.
    always_comb begin
        pipe_v_d[0] = win_valid_q;
        if (win_valid_q) begin
            pipe_a_d[0] = win_base_q + CENTER_OFS;
        end else begin
            pipe_a_d[0] = '0;
        end
        for (int i = 1; i < SOBEL_LAT; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_a_d[i] = pipe_a_q[i-1];
        end
    end

    // State, counters, latency pipe and output flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_addr_q     <= '0;
            win_base_q    <= '0;
            win_col_q     <= '0;
            rd_addr_q     <= '0;
            drain_cnt_q   <= '0;
            in_ready_q    <= 1'b0;
            win_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            border_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pipe_v_q      <= '0;
            for (int i = 0; i < SOBEL_LAT; i++) begin
                pipe_a_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            win_base_q    <= win_base_d;
            win_col_q     <= win_col_d;
            rd_addr_q     <= rd_addr_d;
            drain_cnt_q   <= drain_cnt_d;
            in_ready_q    <= in_ready_d;
            win_valid_q   <= win_valid_d;
            out_valid_q   <= out_valid_d;
            border_zero_q <= border_zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pipe_v_q      <= pipe_v_d;
            for (int i = 0; i < SOBEL_LAT; i++) begin
                pipe_a_q[i] <= pipe_a_d[i];
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign wr_addr     = wr_addr_q;
    assign win_valid   = win_valid_q;
    assign win_base    = win_base_q;
    assign res_wr_en   = pipe_v_q[SOBEL_LAT-1];
    assign res_addr    = pipe_a_q[SOBEL_LAT-1];
    assign out_valid   = out_valid_q;
    assign rd_addr     = rd_addr_q;
    assign border_zero = border_zero_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for sobel_frame_ctrl. Two instances (SOBEL_LAT=1 and SOBEL_LAT=3)
// share one stimulus stream. A frame-level model (phase + beat/window indices,
// window addresses from row/column arithmetic, a history of windows for the
// core latency) is checked against every output on every falling edge, and a
// set of hand-computed cycle numbers and counts pins the model itself.
// Cycle n of a frame is the clock period after the n-th rising edge counted
// from the edge that sampled start (that edge is cycle 0's end).
// -----------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, in_valid, out_ready;
    logic       in_ready_o [2];
    logic       wr_en_o    [2];
    logic [5:0] wr_addr_o  [2];
    logic       win_valid_o[2];
    logic [5:0] win_base_o [2];
    logic       res_wr_en_o[2];
    logic [5:0] res_addr_o [2];
    logic       out_valid_o[2];
    logic [5:0] rd_addr_o  [2];
    logic       border_o   [2];
    logic       busy_o     [2];
    logic       done_o     [2];

    sobel_frame_ctrl #(.SIDE(8), .ADDR_W(6), .SOBEL_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_o[0]), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]),
        .win_valid(win_valid_o[0]), .win_base(win_base_o[0]),
        .res_wr_en(res_wr_en_o[0]), .res_addr(res_addr_o[0]),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .rd_addr(rd_addr_o[0]),
        .border_zero(border_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    sobel_frame_ctrl #(.SIDE(8), .ADDR_W(6), .SOBEL_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_o[1]), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]),
        .win_valid(win_valid_o[1]), .win_base(win_base_o[1]),
        .res_wr_en(res_wr_en_o[1]), .res_addr(res_addr_o[1]),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .rd_addr(rd_addr_o[1]),
        .border_zero(border_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, m, $time, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    // phase: 0 idle, 1 load, 2 compute, 3 drain, 4 unload
    int  ph[2], nin[2], kk[2], dd[2], nout[2];
    bit  dn[2];
    bit  hv[2][5];
    int  ha[2][5];
    int  edge_cnt = 0;
    int  t0 = 0;

    function automatic int lat_of(input int m);
        return (m == 0) ? 1 : 3;
    endfunction

    function automatic int base_of(input int k);
        return 8 * (k / 6) + (k % 6);
    endfunction

    function automatic bit border_of(input int a);
        int r;
        int c;
        r = a / 8;
        c = a % 8;
        return (r == 0) || (r == 7) || (c == 0) || (c == 7);
    endfunction

    task automatic model_step(input int m);
        if (reset) begin
            ph[m] = 0; nin[m] = 0; kk[m] = 0; dd[m] = 0; nout[m] = 0; dn[m] = 0;
            for (int i = 0; i < 5; i++) begin
                hv[m][i] = 0;
                ha[m][i] = 0;
            end
        end else begin
            dn[m] = 0;
            case (ph[m])
                0: if (start) ph[m] = 1;
                1: if (in_valid) begin
                       if (nin[m] == 63) begin ph[m] = 2; nin[m] = 0; kk[m] = 0; end
                       else nin[m]++;
                   end
                2: if (kk[m] == 35) begin ph[m] = 3; kk[m] = 0; dd[m] = 0; end
                   else kk[m]++;
                3: if (dd[m] == lat_of(m) - 1) begin ph[m] = 4; nout[m] = 0; end
                   else dd[m]++;
                4: if (out_ready) begin
                       if (nout[m] == 63) begin ph[m] = 0; dn[m] = 1; nout[m] = 0; end
                       else nout[m]++;
                   end
                default: ph[m] = 0;
            endcase
            for (int i = 4; i > 0; i--) begin
                hv[m][i] = hv[m][i-1];
                ha[m][i] = ha[m][i-1];
            end
            hv[m][0] = (ph[m] == 2);
            ha[m][0] = base_of(kk[m]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
        model_step(0);
        model_step(1);
    end

    // ---------------- observations for hand-computed pins ----------------
    int n_wr[2], first_win[2], n_res[2], first_res[2], last_res[2], min_res[2], max_res[2];
    int first_out[2], n_beats[2], n_brd[2], brd9[2], brd15[2], n_at20[2], done_cyc[2];
    int late_res[2], late_done[2];
    bit watch = 0;
    bit chk_en = 0;

    task automatic clear_stats();
        for (int m = 0; m < 2; m++) begin
            n_wr[m] = 0; first_win[m] = 0; n_res[m] = 0; first_res[m] = 0; last_res[m] = 0;
            min_res[m] = 99; max_res[m] = -1; first_out[m] = 0; n_beats[m] = 0; n_brd[m] = 0;
            brd9[m] = -1; brd15[m] = -1; n_at20[m] = 0; done_cyc[m] = 0;
            late_res[m] = 0; late_done[m] = 0;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                int l;
                int cyc;
                l   = lat_of(m);
                cyc = edge_cnt - t0 + 1;
                chk("in_ready",    m, in_ready_o[m],  (ph[m] == 1));
                chk("wr_en",       m, wr_en_o[m],     (ph[m] == 1) && in_valid);
                chk("wr_addr",     m, wr_addr_o[m],   nin[m]);
                chk("win_valid",   m, win_valid_o[m], (ph[m] == 2));
                chk("win_base",    m, win_base_o[m],  (ph[m] == 2) ? base_of(kk[m]) : 0);
                chk("res_wr_en",   m, res_wr_en_o[m], hv[m][l]);
                if (hv[m][l]) chk("res_addr", m, res_addr_o[m], ha[m][l] + 9);
                chk("out_valid",   m, out_valid_o[m], (ph[m] == 4));
                chk("rd_addr",     m, rd_addr_o[m],   nout[m]);
                chk("border_zero", m, border_o[m],    (ph[m] == 4) && border_of(nout[m]));
                chk("busy",        m, busy_o[m],      (ph[m] != 0));
                chk("done",        m, done_o[m],      dn[m]);

                if (wr_en_o[m]) n_wr[m]++;
                if (win_valid_o[m] && first_win[m] == 0) first_win[m] = cyc;
                if (res_wr_en_o[m]) begin
                    n_res[m]++;
                    if (first_res[m] == 0) first_res[m] = cyc;
                    last_res[m] = cyc;
                    if (int'(res_addr_o[m]) < min_res[m]) min_res[m] = int'(res_addr_o[m]);
                    if (int'(res_addr_o[m]) > max_res[m]) max_res[m] = int'(res_addr_o[m]);
                end
                if (out_valid_o[m]) begin
                    if (first_out[m] == 0) first_out[m] = cyc;
                    if (out_ready) n_beats[m]++;
                    if (out_ready && border_o[m]) n_brd[m]++;
                    if (rd_addr_o[m] == 6'd9)  brd9[m]  = int'(border_o[m]);
                    if (rd_addr_o[m] == 6'd15) brd15[m] = int'(border_o[m]);
                    if (rd_addr_o[m] == 6'd20) n_at20[m]++;
                end
                if (done_o[m] && done_cyc[m] == 0) done_cyc[m] = cyc;
                if (watch && res_wr_en_o[m]) late_res[m]++;
                if (watch && done_o[m]) late_done[m]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 1 streaming, 2 in_valid toggling, 3 out_ready stall at rd 20,
    // 5 start pulse in COMPUTE with in_valid held high, 6 reset at COMPUTE cycle 10
    task automatic run_frame(input int mode);
        int stall;
        int c;
        stall = 0;
        clear_stats();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        t0    = edge_cnt;
        start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done_cyc[0] != 0 && done_cyc[1] != 0) break;
            c = edge_cnt - t0 + 1;
            if (mode == 2) in_valid = (c % 2) == 1;
            if (mode == 3) begin
                if (ph[0] == 4 && nout[0] == 20 && stall < 5) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            if (mode == 5) start = (c == 70);
            if (mode == 6 && c == 74) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                watch = 1'b1;
                chk("busy_after_reset", 0, busy_o[0], 0);
                chk("busy_after_reset", 1, busy_o[1], 0);
                for (int j = 0; j < 200; j++) tick();
                watch = 1'b0;
                chk("res_after_reset",  0, late_res[0], 0);
                chk("res_after_reset",  1, late_res[1], 0);
                chk("done_after_reset", 0, late_done[0], 0);
                chk("done_after_reset", 1, late_done[1], 0);
                return;
            end
            tick();
        end
        chk("frame_completed", 0, (done_cyc[0] != 0 && done_cyc[1] != 0), 1);
        start = 1'b0;
        for (int j = 0; j < 4; j++) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_busy",  0, busy_o[0], 0);
        chk("reset_ready", 1, in_ready_o[1], 0);
        chk("reset_done",  0, done_o[0], 0);
        reset = 1'b0;
        tick();

        // 1 / 4: streaming frame on both latencies
        run_frame(1);
        chk("t1_wr_count",   0, n_wr[0], 64);
        chk("t1_first_win",  0, first_win[0], 65);
        chk("t1_res_count",  0, n_res[0], 36);
        chk("t1_first_res",  0, first_res[0], 66);
        chk("t1_last_res",   0, last_res[0], 101);
        chk("t1_min_res",    0, min_res[0], 9);
        chk("t1_max_res",    0, max_res[0], 54);
        chk("t1_first_out",  0, first_out[0], 102);
        chk("t1_beats",      0, n_beats[0], 64);
        chk("t1_done_cyc",   0, done_cyc[0], 166);
        chk("t1_border_cnt", 0, n_brd[0], 28);
        chk("t4_first_res",  1, first_res[1], 68);
        chk("t4_last_res",   1, last_res[1], 103);
        chk("t4_res_count",  1, n_res[1], 36);
        chk("t4_first_out",  1, first_out[1], 104);
        chk("t4_done_cyc",   1, done_cyc[1], 168);
        chk("t4_border_cnt", 1, n_brd[1], 28);
        chk("t4_border_9",   1, brd9[1], 0);
        chk("t4_border_15",  1, brd15[1], 1);

        // 2: LOAD back-pressure
        run_frame(2);
        chk("t2_wr_count",  0, n_wr[0], 64);
        chk("t2_wr_count",  1, n_wr[1], 64);
        chk("t2_first_win", 0, first_win[0], 128);
        chk("t2_done_cyc",  0, done_cyc[0], 229);
        chk("t2_done_cyc",  1, done_cyc[1], 231);

        // 3: UNLOAD back-pressure
        run_frame(3);
        chk("t3_cycles_at20", 0, n_at20[0], 6);
        chk("t3_beats",       0, n_beats[0], 64);
        chk("t3_done_cyc",    0, done_cyc[0], 171);
        chk("t3_done_cyc",    1, done_cyc[1], 173);

        // 5: start during COMPUTE, in_valid high during UNLOAD
        run_frame(5);
        chk("t5_wr_count", 0, n_wr[0], 64);
        chk("t5_done_cyc", 0, done_cyc[0], 166);
        chk("t5_idle",     0, busy_o[0], 0);
        chk("t5_idle",     1, busy_o[1], 0);

        // 6: reset mid-COMPUTE, then a clean frame
        run_frame(6);
        run_frame(1);
        chk("t6_res_count", 0, n_res[0], 36);
        chk("t6_done_cyc",  0, done_cyc[0], 166);
        chk("t6_done_cyc",  1, done_cyc[1], 168);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
